// File: rtl/mxint8_pkg.sv
// Shared definitions for the MXINT8 quantizer datapath.
// Holds the FP32 field layout, E8M0 constants, the default block size and the
// block-scale FSM state type, plus a helper that extracts the biased exponent.
package mxint8_pkg;

  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_MAN_W    = 23;

  localparam logic [7:0] E8M0_NAN  = 8'hFF;
  localparam int         E8M0_BIAS = 127;

  localparam int DEFAULT_BLOCK_SIZE = 32;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } t_bs_state;

  function automatic logic [7:0] fp32_exp(input logic [31:0] x);
    return x[FP32_EXP_MSB:FP32_EXP_LSB];
  endfunction

endpackage

// File: rtl/mxint8_max_exp.sv
// Running maximum of biased exponents with sticky NaN/Inf detection.
// Latency: next-values are combinational (include the current element); state updates on the edge.
// Backpressure: none; the caller qualifies every update with upd.
// Ports: upd  - element accepted this cycle; first - element opens a new block (loads, not compares);
//        clr  - block finished, return to empty; exp_in - biased exponent of the element;
//        max_next / nan_next - running max and NaN flag including the current element.
module mxint8_max_exp
  import mxint8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic       first,
  input  logic       clr,
  input  logic [7:0] exp_in,
  output logic [7:0] max_next,
  output logic       nan_next
);

  logic [7:0] max_exp;
  logic       nan_sticky;

  always_comb begin
    max_next = max_exp;
    nan_next = nan_sticky;
    if (upd) begin
      if (first || (exp_in > max_exp)) begin
        max_next = exp_in;
      end
      if (exp_in == E8M0_NAN) begin
        nan_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_exp    <= 8'h00;
      nan_sticky <= 1'b0;
    end else if (clr) begin
      max_exp    <= 8'h00;
      nan_sticky <= 1'b0;
    end else if (upd) begin
      max_exp    <= max_next;
      nan_sticky <= nan_next;
    end
  end

endmodule

// File: rtl/mxint8_bd_block_scale.sv
// Collects up to BLOCK_SIZE FP32 scalars into one MX block, computes the shared E8M0 scale
// (max biased exponent, 0xFF if any NaN/Inf) and replays the block in order tagged with that scale.
// Latency: out_valid rises the cycle after the closing element; fill and drain never overlap.
// Backpressure: in_ready is low for the whole drain; out_* hold stable while out_ready is low.
// Ports: in_data/in_valid/in_ready/in_last - FP32 input stream, in_last closes a short block;
//        out_data/out_scale/out_nan/out_valid/out_ready/out_last - replayed block; busy - draining.
module mxint8_bd_block_scale
  import mxint8_pkg::*;
#(
  parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic [31:0] out_data,
  output logic [7:0]  out_scale,
  output logic        out_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);

  localparam int CNT_W = $clog2(BLOCK_SIZE);

  t_bs_state state, state_next;

  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  // One bit wider than the index: a full block holds BLOCK_SIZE elements.
  logic [CNT_W:0]   blk_cnt;
  logic [31:0]      buf_mem [BLOCK_SIZE];

  logic       accept;
  logic       close;
  logic       out_xfer;
  logic       drain_done;
  logic       rd_last;
  logic [7:0] max_next;
  logic       nan_next;

  assign accept     = in_valid && in_ready;
  assign close      = accept && (in_last || (wr_cnt == CNT_W'(BLOCK_SIZE - 1)));
  assign rd_last    = ({1'b0, rd_cnt} == (blk_cnt - (CNT_W + 1)'(1)));
  assign out_xfer   = out_valid && out_ready;
  assign drain_done = out_xfer && rd_last;

  mxint8_max_exp u_max_exp (
    .clk      (clk),
    .rst_n    (rst_n),
    .upd      (accept),
    .first    (wr_cnt == '0),
    .clr      (drain_done),
    .exp_in   (fp32_exp(in_data)),
    .max_next (max_next),
    .nan_next (nan_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (close)      state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // State-derived outputs; in_ready also drops combinationally while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      FILL:  in_ready = rst_n;
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters and per-block tag registers. wr_cnt holds on the closing element so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      blk_cnt   <= '0;
      out_scale <= 8'h00;
      out_nan   <= 1'b0;
    end else begin
      if (close) begin
        blk_cnt   <= {1'b0, wr_cnt} + (CNT_W + 1)'(1);
        out_scale <= nan_next ? E8M0_NAN : max_next;
        out_nan   <= nan_next;
      end else if (accept) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
      if (drain_done) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else if (out_xfer) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

  // Element storage; contents are don't-care outside a valid block, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[wr_cnt] <= in_data;
    end
  end

  assign out_data = out_valid ? buf_mem[rd_cnt] : 32'h0;
  assign out_last = out_valid && rd_last;

endmodule
